// File: rtl/adder_accumulator.sv
// -----------------------------------------------------------------------------
// adder_accumulator
//
// Sums a packet of signed operand beats (each beat is in_a plus a carry-in)
// into one signed WIDTH+1-bit result, in the {co, s} form that the upstream
// adders produce. The packet length is taken from the first beat. One result
// is presented per packet over a valid/ready handshake.
//
// Optional feature macro: ADDACC_SAT_EN
//   defined   -> out_sum clamps to 2^WIDTH-1 / -2^WIDTH when the true sum
//                does not fit in WIDTH+1 signed bits
//   undefined -> out_sum is the wrapped low WIDTH+1 bits of the accumulator
//   out_ovf behaves the same way in both builds.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operand beat valid
//   in_ready   out  block can accept an operand beat (decoded from state only)
//   in_a       in   WIDTH-bit signed operand
//   in_ci      in   carry-in added with this beat
//   len        in   packet length in beats, sampled on the first beat (0 -> 1)
//   out_valid  out  packet result valid
//   out_ready  in   sink accepts the result
//   out_sum    out  WIDTH+1-bit signed packet sum
//   out_ovf    out  true sum did not fit in WIDTH+1 signed bits
// -----------------------------------------------------------------------------
module adder_accumulator #(
    parameter int WIDTH   = 32,
    parameter int COUNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic               in_ci,
    input  logic [COUNT_W-1:0] len,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH:0]     out_sum,
    output logic               out_ovf
);

    // Wide enough that 2^COUNT_W-1 beats of (WIDTH-bit operand + 1) never wrap.
    localparam int AW = WIDTH + COUNT_W + 2;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } state_t;

    state_t                state;
    logic signed [AW-1:0]  acc;
    logic [COUNT_W-1:0]    cnt;
    logic [COUNT_W-1:0]    len_q;

    logic signed [AW-1:0]  term;
    logic signed [AW-1:0]  acc_next;
    logic [COUNT_W-1:0]    len_eff;
    logic [COUNT_W:0]      cnt_inc;
    logic                  last_beat;
    logic [AW-WIDTH-1:0]   upper;
    logic                  ovf_next;
    logic [WIDTH:0]        sum_next;

    assign in_ready = (state != DONE);

    // Per-beat arithmetic, the length bookkeeping that decides whether this
    // beat closes the packet, and the result that would be latched if it does.
    // The first beat starts a fresh sum so acc needs no clearing in IDLE.
    always_comb begin
        term      = '0;
        acc_next  = '0;
        len_eff   = '0;
        cnt_inc   = '0;
        last_beat = 1'b0;
        upper     = '0;
        ovf_next  = 1'b0;
        sum_next  = '0;

        term = {{(AW-WIDTH){in_a[WIDTH-1]}}, in_a} + {{(AW-1){1'b0}}, in_ci};

        if (state == IDLE) begin
            acc_next = term;
        end else begin
            acc_next = acc + term;
        end

        len_eff = (len == '0) ? {{(COUNT_W-1){1'b0}}, 1'b1} : len;
        cnt_inc = {1'b0, cnt} + {{COUNT_W{1'b0}}, 1'b1};

        if (state == IDLE) begin
            last_beat = (len_eff == {{(COUNT_W-1){1'b0}}, 1'b1});
        end else begin
            last_beat = (cnt_inc == {1'b0, len_q});
        end

        // The sum fits in WIDTH+1 signed bits exactly when every bit from
        // WIDTH upward is a copy of the same sign.
        upper    = acc_next[AW-1:WIDTH];
        ovf_next = !((&upper) || !(|upper));

`ifdef ADDACC_SAT_EN
        if (ovf_next) begin
            sum_next = acc_next[AW-1] ? {1'b1, {WIDTH{1'b0}}}
                                      : {1'b0, {WIDTH{1'b1}}};
        end else begin
            sum_next = acc_next[WIDTH:0];
        end
`else
        sum_next = acc_next[WIDTH:0];
`endif
    end

    // Packet FSM. The result registers are loaded on the same edge that
    // accepts the last beat, so out_valid rises one edge after that beat and
    // the outputs never see in_* combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            cnt       <= '0;
            len_q     <= '0;
            out_valid <= 1'b0;
            out_sum   <= '0;
            out_ovf   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        len_q <= len_eff;
                        acc   <= acc_next;
                        cnt   <= {{(COUNT_W-1){1'b0}}, 1'b1};
                        if (last_beat) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= sum_next;
                            out_ovf   <= ovf_next;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end

                ACCUM: begin
                    if (in_valid) begin
                        acc <= acc_next;
                        cnt <= cnt_inc[COUNT_W-1:0];
                        if (last_beat) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_sum   <= sum_next;
                            out_ovf   <= ovf_next;
                        end
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc       <= '0;
                        cnt       <= '0;
                        out_valid <= 1'b0;
                        out_sum   <= '0;
                        out_ovf   <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_accumulator.sv
// -----------------------------------------------------------------------------
// tb_adder_accumulator
//
// Table of directed packets, hand-written multi-cycle sequences (gaps,
// backpressure, ignored len change, mid-packet reset) and randomized packets
// checked against an arithmetic model of the packet sum.
// -----------------------------------------------------------------------------
module tb_adder_accumulator;

    localparam int WIDTH   = 32;
    localparam int COUNT_W = 8;

`ifdef ADDACC_SAT_EN
    localparam logic [WIDTH:0] EXP_POS_OVF = 33'h0_FFFFFFFF;
    localparam logic [WIDTH:0] EXP_NEG_OVF = 33'h1_00000000;
`else
    localparam logic [WIDTH:0] EXP_POS_OVF = 33'h1_7FFFFFFE;
    localparam logic [WIDTH:0] EXP_NEG_OVF = 33'h0_80000000;
`endif

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic               in_ci;
    logic [COUNT_W-1:0] len;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH:0]     out_sum;
    logic               out_ovf;

    int total_cnt = 0;
    int bad_cnt   = 0;

    adder_accumulator #(.WIDTH(WIDTH), .COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_ci     (in_ci),
        .len       (len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int                    n;
        logic [COUNT_W-1:0]    len;
        logic [3:0][WIDTH-1:0] a;
        logic [3:0]            ci;
        logic [WIDTH:0]        exp_sum;
        logic                  exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act !== exp) begin
            bad_cnt++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, wait (bounded) for in_ready, and hold it across the
    // accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic ci,
                                 input logic [COUNT_W-1:0] l);
        int waited = 0;
        in_a     = a;
        in_ci    = ci;
        len      = l;
        in_valid = 1'b1;
        while (!in_ready && waited < 50) begin
            step();
            waited++;
        end
        if (!in_ready) begin
            total_cnt++;
            bad_cnt++;
            $display("[TB] FAIL beat_accept actual=in_ready_low required=in_ready_high");
        end
        step();
        in_valid = 1'b0;
    endtask

    // Compare the presented result, then complete the output handshake and
    // confirm the block is back to accepting beats.
    task automatic checkOutput(input string name, input logic [WIDTH:0] exp_sum,
                               input logic exp_ovf);
        check({name, "_valid"}, 64'(out_valid), 64'(1'b1));
        check({name, "_sum"}, 64'(out_sum), 64'(exp_sum));
        check({name, "_ovf"}, 64'(out_ovf), 64'(exp_ovf));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({name, "_valid_clr"}, 64'(out_valid), 64'(1'b0));
        check({name, "_in_ready"}, 64'(in_ready), 64'(1'b1));
    endtask

    // Reference: exact integer sum, compared against the WIDTH+1-bit signed range.
    function automatic void model(input longint total, output logic [WIDTH:0] s,
                                  output logic o);
        o = (total > 64'sh0_FFFFFFFF) || (total < -64'sh1_00000000);
`ifdef ADDACC_SAT_EN
        if (o) s = (total > 0) ? 33'h0_FFFFFFFF : 33'h1_00000000;
        else   s = total[WIDTH:0];
`else
        s = total[WIDTH:0];
`endif
    endfunction

    initial begin
        logic [WIDTH:0] held_sum;
        logic [WIDTH:0] m_sum;
        logic           m_ovf;

        vecs[0] = '{1, 8'd1, {32'd0, 32'd0, 32'd0, 32'd5}, 4'b0001, 33'h0_00000006, 1'b0};
        vecs[1] = '{2, 8'd2, {32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF}, 4'b0010, 33'h1_FFFFFFFF, 1'b0};
        vecs[2] = '{3, 8'd3, {32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF}, 4'b0100, EXP_POS_OVF, 1'b1};
        vecs[3] = '{1, 8'd0, {32'd0, 32'd0, 32'd0, 32'd10}, 4'b0000, 33'h0_0000000A, 1'b0};
        vecs[4] = '{3, 8'd3, {32'd0, 32'h80000000, 32'h80000000, 32'h80000000}, 4'b0000, EXP_NEG_OVF, 1'b1};
        vecs[5] = '{4, 8'd4, {32'd4, 32'd3, 32'd2, 32'd1}, 4'b1001, 33'h0_0000000C, 1'b0};
        vecs[6] = '{2, 8'd2, {32'd0, 32'd0, 32'h7FFFFFFF, 32'h7FFFFFFF}, 4'b0001, 33'h0_FFFFFFFF, 1'b0};
        vecs[7] = '{2, 8'd2, {32'd0, 32'd0, 32'h80000000, 32'h80000000}, 4'b0000, 33'h1_00000000, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_ci     = 1'b0;
        len       = '0;
        out_ready = 1'b0;
        #2;
        check("rst_out_valid", 64'(out_valid), 64'(1'b0));
        check("rst_out_sum", 64'(out_sum), 64'd0);
        check("rst_out_ovf", 64'(out_ovf), 64'(1'b0));
        check("rst_in_ready", 64'(in_ready), 64'(1'b1));
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < vecs[i].n; j++)
                applyStimulus(vecs[i].a[j], vecs[i].ci[j], vecs[i].len);
            checkOutput($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_ovf);
        end

        // Gaps mid-packet, then backpressure with ignored in_valid pulses.
        applyStimulus(32'd100, 1'b0, 8'd4);
        applyStimulus(-32'sd50, 1'b1, 8'd4);
        step();
        step();
        check("gap_in_ready", 64'(in_ready), 64'(1'b1));
        check("gap_no_result", 64'(out_valid), 64'(1'b0));
        applyStimulus(32'd20, 1'b0, 8'd4);
        applyStimulus(32'd3, 1'b1, 8'd4);
        held_sum = 33'd75;
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_a     = 32'd999;
            step();
            check($sformatf("hold%0d_valid", k), 64'(out_valid), 64'(1'b1));
            check($sformatf("hold%0d_sum", k), 64'(out_sum), 64'(held_sum));
            check($sformatf("hold%0d_in_ready", k), 64'(in_ready), 64'(1'b0));
        end
        in_valid = 1'b0;
        checkOutput("gap_pkt", held_sum, 1'b0);
        applyStimulus(32'd1, 1'b0, 8'd1);
        checkOutput("after_hold", 33'd1, 1'b0);

        // len changed on beat 2 must not shorten the packet.
        applyStimulus(32'd5, 1'b0, 8'd3);
        applyStimulus(32'd6, 1'b0, 8'd1);
        check("lenchg_no_early", 64'(out_valid), 64'(1'b0));
        check("lenchg_in_ready", 64'(in_ready), 64'(1'b1));
        applyStimulus(32'd7, 1'b0, 8'd1);
        checkOutput("lenchg", 33'd18, 1'b0);

        // Reset between edges in the middle of a packet.
        applyStimulus(32'd11, 1'b0, 8'd4);
        applyStimulus(32'd12, 1'b0, 8'd4);
        #3 rst_n = 1'b0;
        #1;
        check("midrst_valid", 64'(out_valid), 64'(1'b0));
        check("midrst_sum", 64'(out_sum), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'(1'b1));
        #2 rst_n = 1'b1;
        step();
        applyStimulus(32'd7, 1'b0, 8'd1);
        checkOutput("post_rst", 33'd7, 1'b0);

        // Randomized packets against the arithmetic model.
        for (int p = 0; p < 40; p++) begin
            int                 n;
            logic [COUNT_W-1:0] l;
            longint             total;
            logic [WIDTH-1:0]   a;
            logic               ci;
            n     = $urandom_range(1, 6);
            l     = COUNT_W'(n);
            if (n == 1 && $urandom_range(0, 1) == 1) l = '0;
            total = 0;
            for (int b = 0; b < n; b++) begin
                case ($urandom_range(0, 3))
                    0:       a = 32'h7FFFFFFF;
                    1:       a = 32'h80000000;
                    default: a = $urandom;
                endcase
                ci = 1'($urandom_range(0, 1));
                total += longint'($signed(a)) + longint'(ci);
                repeat ($urandom_range(0, 2)) step();
                applyStimulus(a, ci, (b == 0) ? l : COUNT_W'($urandom));
            end
            repeat ($urandom_range(0, 3)) step();
            model(total, m_sum, m_ovf);
            checkOutput($sformatf("rand%0d", p), m_sum, m_ovf);
        end

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/adder_accumulator.md
Name: adder_accumulator

Overview:
- Sequential stage directly downstream of the 32-bit adder family: consumes a stream of signed operands with carry-in and accumulates them into one signed WIDTH+1-bit result, using the {co, s} convention the adders use.
- Operands arrive as packets of a programmable length over a valid/ready handshake; one result is presented per packet.
- Sits between the adder datapath and any result sink, such as a checker or register file.

Parameters:
- WIDTH, 32, operand width in bits (signed two's complement).
- COUNT_W, 8, width of the packet-length field and the internal beat counter.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept an operand beat.
- in_a  input  WIDTH  signed operand.
- in_ci  input  1  carry-in added with this beat (+0 or +1).
- len  input  COUNT_W  number of beats in the packet; sampled on the first beat only.
- out_valid  output  1  result valid.
- out_ready  input  1  sink accepts the result.
- out_sum  output  WIDTH+1  signed packet sum.
- out_ovf  output  1  the true sum did not fit in WIDTH+1 signed bits.

Behaviour:
- Reset (async assert, sync release on clk):
  - state=IDLE; acc, cnt, len_q = 0.
  - out_valid=0, out_sum=0, out_ovf=0, in_ready=1.
- Internal accumulator width: WIDTH+COUNT_W+2 bits, signed. It never wraps for any legal len.
- Each term added is sign-extended in_a plus zero-extended in_ci.
- States: IDLE, ACCUM, DONE.
- IDLE (in_ready=1):
  - On in_valid&in_ready: len_q <= (len==0 ? 1 : len); acc <= term; cnt <= 1.
  - Next state is DONE if the effective len is 1, otherwise ACCUM.
- ACCUM (in_ready=1):
  - On handshake: acc <= acc+term; cnt <= cnt+1.
  - When cnt+1==len_q, next state is DONE.
  - Cycles with in_valid=0 leave all state unchanged.
- DONE (in_ready=0, out_valid=1):
  - out_sum = acc[WIDTH:0].
  - out_ovf = 1 iff acc lies outside [-2^WIDTH, 2^WIDTH-1].
  - out_sum and out_ovf stay stable while out_valid&!out_ready.
  - On out_ready: next state is IDLE, acc <= 0, cnt <= 0.
- Latency: out_valid rises on the clock edge after the last beat is accepted.
- Back-to-back packets: at least one bubble, because in_ready=0 in DONE. The next packet's first beat can be accepted the cycle after the result handshake.
- len changes after the first beat are ignored until the next packet.
- in_valid while in DONE: ignored, no data lost because in_ready=0.
- Reset mid-packet: acc is discarded, the block returns to IDLE immediately, and no result is produced for the partial packet.
- Outputs are registered; no combinational path from in_* to out_*.
- in_ready depends on state only.

Optional Feature:
- Macro: ADDACC_SAT_EN.
- Defined: on overflow, out_sum saturates to 2^WIDTH-1 (positive overflow) or -2^WIDTH (negative overflow). out_ovf is still asserted.
- Undefined: out_sum is the wrapped low WIDTH+1 bits of acc. out_ovf behaves identically.

Test Plan:
- Single beat: len=1, in_a=5, in_ci=1 -> next cycle out_valid=1, out_sum=33'h0_00000006, out_ovf=0; out_ready=1 returns the block to IDLE, in_ready=1.
- Signed cancel: len=2, beats (a=-1, ci=0), (a=-1, ci=1) -> out_sum=33'h1_FFFFFFFF (-1), out_ovf=0.
- Overflow: len=3, three beats a=32'h7FFFFFFF with ci=0,0,1 -> out_ovf=1.
  - Without ADDACC_SAT_EN: out_sum=33'h1_7FFFFFFE.
  - With ADDACC_SAT_EN: out_sum=33'h0_FFFFFFFF.
- Backpressure and gaps:
  - len=4 with in_valid low for 2 cycles mid-packet: result equals the sum of the 4 beats.
  - Then hold out_ready=0 for 5 cycles: out_valid stays 1, out_sum is stable, in_ready=0, and in_valid pulses are ignored.
- len=0 -> behaves as len=1. A new len value presented on beat 2 of a len=3 packet is ignored (the packet still takes 3 beats).
- Reset mid-packet: after 2 of 4 beats, pulse rst_n low asynchronously between edges -> out_valid=0, out_sum=0, in_ready=1 immediately. A following len=1, a=7 packet yields out_sum=7.
